// File: rtl/adder_pkg.sv
// Shared definitions for the segmented pipelined adder: stage-count helper,
// parameter legality check and the per-stage carry/valid bundle.
package adder_pkg;

    typedef struct packed {
        logic carry;
        logic vld;
    } stage_ctl_t;

    function automatic int nstg(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit seg_ok(input int width, input int seg);
        return (width >= 1) && (seg >= 1) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit ripple-carry slice built from generate/propagate terms.
module adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < SEG; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        co = c;
    end

endmodule

// File: rtl/adder_pipe.sv
// Pipelined adder/subtractor resolving one SEG-bit segment per stage; a single
// global enable (adv) moves every stage together so control stays trivial.
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = nstg(WIDTH, SEG);

    if (!seg_ok(WIDTH, SEG)) begin : g_param_check
        $error("adder_pipe: WIDTH must be a positive multiple of SEG");
    end

    logic adv;

    // Element k of each array is what stage k consumes: remaining operand
    // segments shifted down to bit 0, the partially assembled sum, carry/valid.
    logic [WIDTH-1:0] op_a   [NSTG];
    logic [WIDTH-1:0] op_b   [NSTG];
    logic [WIDTH-1:0] acc_in [NSTG];
    stage_ctl_t       ctl_in [NSTG];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign op_a[0]   = a;
    assign op_b[0]   = sub ? ~b : b;
    assign acc_in[0] = '0;
    assign ctl_in[0] = '{carry: sub | cin, vld: in_valid};

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [SEG-1:0]   seg_s;
        logic             seg_co;
        logic [WIDTH-1:0] seg_sum;

        adder_seg #(.SEG(SEG)) u_seg (
            .a  (op_a[k][SEG-1:0]),
            .b  (op_b[k][SEG-1:0]),
            .ci (ctl_in[k].carry),
            .s  (seg_s),
            .co (seg_co)
        );

        assign seg_sum = acc_in[k] | (WIDTH'(seg_s) << (k * SEG));

        if (k < NSTG - 1) begin : g_mid
            logic [WIDTH-1:0] a_r;
            logic [WIDTH-1:0] b_r;
            logic [WIDTH-1:0] sum_r;
            stage_ctl_t       ctl_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ctl_r <= '0;
                end else if (adv) begin
                    ctl_r <= '{carry: seg_co, vld: ctl_in[k].vld};
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    a_r   <= op_a[k] >> SEG;
                    b_r   <= op_b[k] >> SEG;
                    sum_r <= seg_sum;
                end
            end

            assign op_a[k+1]   = a_r;
            assign op_b[k+1]   = b_r;
            assign acc_in[k+1] = sum_r;
            assign ctl_in[k+1] = ctl_r;
        end else begin : g_last
            logic [WIDTH-1:0] sum_r;
            stage_ctl_t       ctl_r;
            logic             ovf_r;

            // Top segment: operand sign bits are op_*[SEG-1], result sign is seg_s[SEG-1].
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctl_r <= '0;
                    sum_r <= '0;
                    ovf_r <= 1'b0;
                end else if (adv) begin
                    ctl_r <= '{carry: seg_co, vld: ctl_in[k].vld};
                    sum_r <= seg_sum;
                    ovf_r <= (op_a[k][SEG-1] == op_b[k][SEG-1]) &&
                             (seg_s[SEG-1] != op_a[k][SEG-1]);
                end
            end

            assign sum       = sum_r;
            assign cout      = ctl_r.carry;
            assign out_valid = ctl_r.vld;
            assign ovf       = ovf_r;
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed cases, backpressured random stream, mid-flight
// reset and a (WIDTH,SEG) sweep, all checked against an arithmetic reference.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic        ir16, ov16, co16, of16;
    logic [15:0] s16;
    logic        ir3a, ov3a, co3a, of3a;
    logic [2:0]  s3a;
    logic        ir3b, ov3b, co3b, of3b;
    logic [2:0]  s3b;
    logic        ir32, ov32, co32, of32;
    logic [31:0] s32;

    adder_pipe #(.WIDTH(16), .SEG(4)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
        .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16), .ovf(of16)
    );
    adder_pipe #(.WIDTH(3), .SEG(3)) u_d3a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3a),
        .a(a[2:0]), .b(b[2:0]), .cin(cin), .sub(sub),
        .out_valid(ov3a), .out_ready(out_ready), .sum(s3a), .cout(co3a), .ovf(of3a)
    );
    adder_pipe #(.WIDTH(3), .SEG(1)) u_d3b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3b),
        .a(a[2:0]), .b(b[2:0]), .cin(cin), .sub(sub),
        .out_valid(ov3b), .out_ready(out_ready), .sum(s3b), .cout(co3b), .ovf(of3b)
    );
    adder_pipe #(.WIDTH(32), .SEG(8)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32), .ovf(of32)
    );

    logic [31:0] os [4];
    logic        ov [4];
    logic        oc [4];
    logic        oo [4];
    logic        ir [4];
    int          wid     [4] = '{16, 3, 3, 32};
    int          lat_exp [4] = '{16 / 4, 3 / 3, 3 / 1, 32 / 8};

    assign os[0] = {16'd0, s16};
    assign os[1] = {29'd0, s3a};
    assign os[2] = {29'd0, s3b};
    assign os[3] = s32;
    assign ov[0] = ov16;  assign ov[1] = ov3a;  assign ov[2] = ov3b;  assign ov[3] = ov32;
    assign oc[0] = co16;  assign oc[1] = co3a;  assign oc[2] = co3b;  assign oc[3] = co32;
    assign oo[0] = of16;  assign oo[1] = of3a;  assign oo[2] = of3b;  assign oo[3] = of32;
    assign ir[0] = ir16;  assign ir[1] = ir3a;  assign ir[2] = ir3b;  assign ir[3] = ir32;

    // Returns {cout, ovf, sum} from unsigned and signed integer arithmetic.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] ai,
                                              input logic [31:0] bi, input logic ci,
                                              input logic si);
        longint m, au, bu, sa, sb, r, hi, lo;
        logic [31:0] s;
        logic c, o;
        m  = (longint'(1) << w) - 1;
        au = longint'(ai) & m;
        bu = longint'(bi) & m;
        if (si) begin
            r = au - bu;
            c = (au >= bu);
        end else begin
            r = au + bu + longint'(ci);
            c = ((r >> w) != 0);
        end
        s  = 32'(r & m);
        sa = (au >= (longint'(1) << (w - 1))) ? au - (longint'(1) << w) : au;
        sb = (bu >= (longint'(1) << (w - 1))) ? bu - (longint'(1) << w) : bu;
        r  = si ? (sa - sb) : (sa + sb + longint'(ci));
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        o  = (r > hi) || (r < lo);
        return {c, o, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic flush(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input int idx, input logic [31:0] ai, input logic [31:0] bi,
                        input logic ci, input logic si, input logic [31:0] es,
                        input logic ec, input logic eo);
        int lat;
        a = ai; b = bi; cin = ci; sub = si;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!ov[idx] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, lat_exp[idx]);
        chk("sum", os[idx], es);
        chk("cout", oc[idx], ec);
        chk("ovf", oo[idx], eo);
    endtask

    task automatic beat_rand(input int idx);
        logic [31:0] ai, bi;
        logic        ci, si;
        logic [33:0] e;
        ai = $urandom; bi = $urandom;
        ci = 1'($urandom_range(0, 1));
        si = 1'($urandom_range(0, 1));
        e  = ref_model(wid[idx], ai, bi, ci, si);
        beat(idx, ai, bi, ci, si, e[31:0], e[33], e[32]);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] q[$];
        logic [33:0] e;
        logic [31:0] held_s, na, nb;
        logic        nc, stall_prev;
        int          sent, rcvd;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, with out_ready low: in_ready must still be 1.
        for (int i = 0; i < 4; i++) begin
            chk("rst_out_valid", ov[i], 1'b0);
            chk("rst_sum", os[i], 32'd0);
            chk("rst_cout", oc[i], 1'b0);
            chk("rst_ovf", oo[i], 1'b0);
            chk("rst_in_ready", ir[i], 1'b1);
        end

        // Directed cases on the 16/4 instance.
        beat(0, 32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0, 1'b0);
        beat(0, 32'hFFFF, 32'h0000, 1'b1, 1'b0, 32'h0000, 1'b1, 1'b0);
        beat(0, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
        beat(0, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0);
        beat(0, 32'h8000, 32'h0001, 1'b0, 1'b1, 32'h7FFF, 1'b1, 1'b1);
        beat(0, 32'h0003, 32'h0003, 1'b1, 1'b1, 32'h0000, 1'b1, 1'b0);

        // Back-to-back stream with out_ready toggling on a period of 3.
        flush(8);
        sent = 0; rcvd = 0; stall_prev = 1'b0; held_s = '0;
        na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 200 && rcvd < 10; cyc++) begin
            if (stall_prev) begin
                chk("stall_sum", os[0], held_s);
                chk("stall_valid", ov[0], 1'b1);
            end
            out_ready = ((cyc % 3) != 2);
            in_valid  = (sent < 10);
            a = na; b = nb; cin = nc; sub = 1'b0;
            #1;
            chk("in_ready", ir[0], !ov[0] || out_ready);
            if (ov[0] && out_ready) begin
                chk("stream_queue_nonempty", q.size() > 0, 1'b1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("stream_sum", os[0], e[31:0]);
                    chk("stream_cout", oc[0], e[33]);
                    chk("stream_ovf", oo[0], e[32]);
                end
                rcvd++;
            end
            stall_prev = ov[0] && !out_ready;
            held_s     = os[0];
            if (in_valid && ir[0]) begin
                q.push_back(ref_model(16, a, b, cin, 1'b0));
                sent++;
                na = $urandom; nb = $urandom; nc = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        chk("stream_count", rcvd, 10);

        // Reset with three beats in flight: none of them may surface.
        flush(8);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = $urandom; cin = 1'b0; sub = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_out_valid", ov[0], 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_stale", ov[0], 1'b0);
        end
        beat(0, 32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0);

        // Parameter sweep: each instance checked on its own latency and results.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int idx = 1; idx < 4; idx++) begin
            flush(8);
            e = ref_model(wid[idx], 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
            beat(idx, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, e[31:0], e[33], e[32]);
            for (int n = 0; n < 6; n++) beat_rand(idx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined ripple-carry adder/subtractor. It succeeds the fixed 3-bit combinational adder partitions. Operands split into SEG-bit segments; one segment resolves per pipeline stage with its carry registered into the next, giving one result per cycle at WIDTH/SEG cycles latency. It sits in the arithmetic datapath behind a valid/ready handshake and is the baseline the approximate-synthesis flow partitions per segment.

## Interface
- WIDTH, 16, operand/result width; must be ≥ 1.
- SEG, 4, segment width per stage; WIDTH % SEG == 0 (elaboration error otherwise).
- NSTG, WIDTH/SEG, derived stage count = latency; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  pipeline accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; used only when sub=0.
- sub  in  1  1: A − B; 0: A + B + cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result, mod 2^WIDTH.
- cout  out  1  carry out of MSB (sub=1: 1 means no borrow, A ≥ B unsigned).
- ovf  out  1  signed overflow.

## Operation
- Beat accepted when in_valid && in_ready. Effective B' = sub ? ~b : b; effective carry c0 = sub ? 1 : cin.
- Stage k (0..NSTG−1) adds segment k of A and B' plus carry from stage k−1 (c0 for stage 0). It registers its SEG sum bits, its carry-out, and the still-unconsumed upper operand segments.
- Completed lower sum segments travel forward in skew registers, so all segments of one beat exit the last stage together.
- ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), computed in the last stage.
- Each stage carries a valid bit. Bubbles are allowed and propagate unchanged.
- Flow control is a global enable: adv = !out_valid || out_ready; in_ready = adv. When adv=0, every stage register, valid bit included, holds.
- Outputs are registered from the last stage. sum/cout/ovf hold stable while out_valid && !out_ready.
- No internal state besides the pipeline; no modes beyond sub.

## Timing
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSTG−1, i.e. NSTG register stages, when no stall occurs. Stalls add cycles 1:1.
- Throughput: 1 beat/cycle when out_ready stays high.
- in_ready is combinational from out_ready and out_valid only, never from in_valid.
- Reset (rst=1 at an edge): all valid bits 0, sum=0, cout=0, ovf=0, out_valid=0. in_ready reads 1 from the cycle after reset. Reset mid-operation discards in-flight beats; nothing emerges from them.
- Simultaneous accept and emit under out_ready=1: both occur and the pipeline shifts.
- Stall with empty last stage: adv=1 because out_valid=0, so bubbles collapse is NOT performed. Every stage shifts together, which keeps control simple.
- NSTG=1 (SEG=WIDTH): degenerates to a single registered adder with latency 1.
- Carry chain per stage is SEG bits, so the critical path scales with SEG, not WIDTH.

## Structure
- Shared package adder_pkg holds:
  - function nstg(width, seg);
  - the elaboration check for WIDTH % SEG;
  - a packed typedef for a stage's carry/valid bundle.
- Sub-module adder_seg: a combinational SEG-bit ripple-carry slice (a, b, ci → s, co), built from the same generate/propagate equations as the existing partitions, instantiated NSTG times.
- Top handles skew registers, valids, sub inversion and ovf.

## Test plan
- Basic add, WIDTH=16/SEG=4: a=0x00FF, b=0x0001, cin=0, sub=0 → after 4 cycles, sum=0x0100, cout=0, ovf=0. This checks carry crossing a segment boundary.
- Full ripple: a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, ovf=0. Signed case: a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1 → sum=0xFFFE, cout=0. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- Back-to-back and backpressure: stream 10 random beats with in_valid=1 and out_ready toggling with period 3. Check 10 results in order, matching the model (a+b+cin mod 2^16), and sum stable during every stall.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle → out_valid stays 0 and no stale beat ever appears. A new beat then emerges after 4 cycles.
- Parameter sweep: (WIDTH,SEG) = (3,3), (3,1), (32,8), with random operands against the reference model. Latency must equal WIDTH/SEG each time.
